// File: rtl/cur_block_loader_if.sv
// Frame-memory read port and current-block buffer write port of the
// current-block loader. The loader is the master on both sides.
interface cur_block_loader_if #(
  parameter int ADDR_W = 20,
  parameter int PIX_W  = 8
) ();
  // frame memory read channel
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [PIX_W-1:0]  mem_rdata;
  // current-block buffer write channel
  logic              buf_we;
  logic [7:0]        buf_addr;
  logic [PIX_W-1:0]  buf_wdata;

  modport master (
    output mem_req, mem_addr, buf_we, buf_addr, buf_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, buf_we, buf_addr, buf_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/cur_block_loader.sv
// Current-block loader: on start, reads the BLK x BLK macroblock at curpos
// from frame memory in raster order with pipelined requests, streams each
// response into the local buffer, and pulses currentfilled when the last
// pixel has been written.
module cur_block_loader #(
  parameter int BLK     = 16,
  parameter int FRAME_W = 1280,
  parameter int ADDR_W  = 20,
  parameter int PIX_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,          // asynchronous, active low
  input  logic                 start,
  input  logic [13:0]          curpos,         // {block_y[13:7], block_x[6:0]}
  cur_block_loader_if.master   bus,
  output logic                 currentfilled,
  output logic                 busy
);

  localparam int LOG_BLK    = $clog2(BLK);
  localparam int CNT_W      = 2 * LOG_BLK;
  localparam int ROW_STRIDE = BLK * FRAME_W;

  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BLK * BLK - 1);
  localparam logic [LOG_BLK-1:0] LAST_COL = LOG_BLK'(BLK - 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

  state_t            state_reg;
  logic              mem_req_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [ADDR_W-1:0] row_addr_reg;
  logic [CNT_W-1:0]  req_cnt_reg;
  logic [CNT_W-1:0]  resp_cnt_reg;
  logic              filled_reg;
  logic              busy_reg;

  logic [ADDR_W-1:0] base_addr;
  logic [31:0]       base_full;
  logic              accept_resp;

  // Block origin in the frame; coordinates are not range-checked, the
  // result simply wraps to the address width.
  always_comb begin
    base_full = 32'(curpos[13:7]) * 32'(ROW_STRIDE) + 32'(curpos[6:0]) * 32'(BLK);
    base_addr = base_full[ADDR_W-1:0];
  end

  // Responses are only meaningful while a load is in flight.
  assign accept_resp = bus.mem_rvalid && (state_reg == REQ || state_reg == DRAIN);

  // Control FSM with request address generation and response counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
      row_addr_reg <= '0;
      req_cnt_reg  <= '0;
      resp_cnt_reg <= '0;
      filled_reg   <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      filled_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            row_addr_reg <= base_addr;
            mem_addr_reg <= base_addr;
            req_cnt_reg  <= '0;
            resp_cnt_reg <= '0;
            mem_req_reg  <= 1'b1;
            busy_reg     <= 1'b1;
            state_reg    <= REQ;
          end
        end
        REQ, DRAIN: begin
          if (state_reg == REQ && bus.mem_gnt) begin
            req_cnt_reg <= req_cnt_reg + 1'b1;
            if (req_cnt_reg[LOG_BLK-1:0] == LAST_COL) begin
              // end of a block row: jump to the start of the next frame line
              row_addr_reg <= row_addr_reg + ADDR_W'(FRAME_W);
              mem_addr_reg <= row_addr_reg + ADDR_W'(FRAME_W);
            end else begin
              mem_addr_reg <= mem_addr_reg + 1'b1;
            end
            if (req_cnt_reg == LAST_CNT) begin
              mem_req_reg <= 1'b0;
              state_reg   <= DRAIN;
            end
          end
          // Last write wins over the DRAIN transition (zero-latency memory).
          if (accept_resp) begin
            resp_cnt_reg <= resp_cnt_reg + 1'b1;
            if (resp_cnt_reg == LAST_CNT) begin
              mem_req_reg <= 1'b0;
              filled_reg  <= 1'b1;
              busy_reg    <= 1'b0;
              state_reg   <= DONE;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.buf_we    = accept_resp;
  assign bus.buf_addr  = 8'(resp_cnt_reg);
  assign bus.buf_wdata = bus.mem_rdata;
  assign currentfilled = filled_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_cur_block_loader.sv
// Bench for cur_block_loader: a frame-memory model with selectable grant
// pattern and read latency, a reference model that lists the expected
// address and buffer-write streams of a load, and a monitor that checks
// every transfer, write and completion pulse against those queues.
module tb_cur_block_loader;

  localparam int ADDR_W = 20;
  localparam int PIX_W  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [13:0] curpos = '0;
  logic        currentfilled;
  logic        busy;

  cur_block_loader_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

  cur_block_loader #(.BLK(16), .FRAME_W(1280), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .curpos       (curpos),
    .bus          (bus),
    .currentfilled(currentfilled),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       idx;
    int       data;
  } wr_t;

  typedef struct {
    int       due;
    int       data;
  } rsp_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   gnt_mode = 0;   // 0 constant, 1 toggling, 2 random
  int   lat = 2;
  bit   spurious = 1'b0;
  bit   load_active = 1'b0;
  bit   done_seen = 1'b0;
  int   exp_done = -1;
  int   exp_addr[$];
  wr_t  exp_wr[$];
  rsp_t rq[$];

  function automatic int pix(input int a);
    return ((a * 37) ^ (a >> 8) ^ (a >> 15)) & 255;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame memory model: grant pattern plus fixed-latency in-order responses.
  initial begin
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        rq.delete();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
      end else begin
        case (gnt_mode)
          0:       bus.mem_gnt = 1'b1;
          1:       bus.mem_gnt = ~bus.mem_gnt;
          default: bus.mem_gnt = 1'($urandom_range(0, 1));
        endcase
        bus.mem_rvalid = 1'b0;
        if (lat == 0) begin
          if (bus.mem_req && bus.mem_gnt) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 8'(pix(int'(bus.mem_addr)));
          end
        end else begin
          if (rq.size() > 0 && rq[0].due == cyc) begin
            rsp_t r;
            r = rq.pop_front();
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 8'(r.data);
          end
          if (bus.mem_req && bus.mem_gnt) begin
            rsp_t r;
            r.due  = cyc + lat;
            r.data = pix(int'(bus.mem_addr));
            rq.push_back(r);
          end
        end
        if (spurious) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = 8'hA5;
        end
      end
    end
  end

  // Monitor: checks each transfer, buffer write and completion pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.mem_req && bus.mem_gnt) begin
          if (exp_addr.size() == 0) chk("xfer_extra", 1, 0);
          else chk("mem_addr", int'(bus.mem_addr), exp_addr.pop_front());
        end
        if (bus.buf_we) begin
          if (exp_wr.size() == 0) chk("buf_we_extra", 1, 0);
          else begin
            wr_t w;
            w = exp_wr.pop_front();
            chk("buf_addr", int'(bus.buf_addr), w.idx);
            chk("buf_wdata", int'(bus.buf_wdata), w.data);
          end
        end
        if (currentfilled) begin
          chk("filled_expected", int'(load_active), 1);
          if (load_active) begin
            if (exp_done >= 0) chk("filled_cycle", cyc, exp_done);
            chk("filled_writes_left", exp_wr.size(), 0);
            chk("filled_busy", int'(busy), 0);
          end
          load_active = 1'b0;
          done_seen   = 1'b1;
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_mem_req"}, int'(bus.mem_req), 0);
    chk({tag, "_mem_addr"}, int'(bus.mem_addr), 0);
    chk({tag, "_buf_we"}, int'(bus.buf_we), 0);
    chk({tag, "_buf_addr"}, int'(bus.buf_addr), 0);
    chk({tag, "_filled"}, int'(currentfilled), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // One load: builds the expected streams, pulses start, waits for the end.
  task automatic run_load(input int x, input int y, input int mode, input int l,
                          input bit repulse, input int rst_at);
    int s;
    int base;
    gnt_mode = mode;
    lat      = l;
    @(posedge clk);
    #2;
    base = (y * 16 * 1280 + x * 16) % (1 << ADDR_W);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        wr_t w;
        int  a;
        a = (base + r * 1280 + c) % (1 << ADDR_W);
        exp_addr.push_back(a);
        w.idx  = r * 16 + c;
        w.data = pix(a);
        exp_wr.push_back(w);
      end
    end
    s           = cyc;
    exp_done    = (mode == 0 && rst_at == 0) ? s + 257 + l : -1;
    load_active = 1'b1;
    done_seen   = 1'b0;
    start       = 1'b1;
    curpos      = {7'(y), 7'(x)};
    @(posedge clk);
    #2;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int k = 0; k < 3000 && !done_seen; k++) begin
      @(posedge clk);
      #2;
      start = 1'b0;
      if (repulse && cyc == s + 50) begin
        start  = 1'b1;
        curpos = {7'(y + 3), 7'(x + 5)};
      end
      if (rst_at != 0 && cyc == s + rst_at) begin
        reset = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        exp_addr.delete();
        exp_wr.delete();
        load_active = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        // a further currentfilled would be flagged by the monitor
        repeat (300) @(posedge clk);
        chk("reset_no_filled", int'(done_seen), 0);
        return;
      end
    end
    if (!done_seen) begin
      chk("load_timeout", 0, 1);
      exp_addr.delete();
      exp_wr.delete();
      load_active = 1'b0;
    end
    chk("addr_left", exp_addr.size(), 0);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #23;
    check_outputs_zero("reset");
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_load(0, 0, 0, 2, 1'b0, 0);
    run_load(79, 44, 0, 1, 1'b0, 0);
    run_load(7, 3, 1, 3, 1'b0, 0);
    run_load(12, 20, 0, 2, 1'b1, 0);
    run_load(30, 10, 0, 2, 1'b0, 100);
    run_load(30, 10, 0, 2, 1'b0, 0);
    run_load(5, 9, 0, 0, 1'b0, 0);

    // rvalid while idle must not write the buffer
    @(posedge clk);
    spurious = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #3;
      chk("idle_rvalid_no_write", int'(bus.buf_we), 0);
    end
    spurious = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_load(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), 1'b0, 0);
    end

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cur_block_loader.md
Name: cur_block_loader

Overview:
Fetches the 16x16 current macroblock at block position curpos from the external frame memory into the local current-block buffer. The motion-estimation controller pulses start on entry to its FillCurrent state. This block then issues 256 pipelined pixel reads in raster order and writes each response into the buffer. When the last pixel is written it pulses currentfilled, which releases the controller into its process state.

Parameters:
BLK, 16, block edge in pixels (a block is BLK*BLK pixels).
FRAME_W, 1280, frame width in pixels (80 blocks).
ADDR_W, 20, frame memory address width (1280*720 = 921600 < 2^20).
PIX_W, 8, pixel width.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to load the block at curpos
curpos  input  14  {block_y[13:7], block_x[6:0]}, sampled on accepted start
mem_req  output  1  read request valid
mem_addr  output  ADDR_W  pixel address; held stable while mem_req=1 and mem_gnt=0
mem_gnt  input  1  request accepted this cycle (req & gnt = one transfer)
mem_rvalid  input  1  read data valid; responses return in request order
mem_rdata  input  PIX_W  read data
buf_we  output  1  current-block buffer write enable
buf_addr  output  8  buffer index, row*16+col
buf_wdata  output  PIX_W  buffer write data
currentfilled  output  1  one-cycle pulse: all 256 pixels written
busy  output  1  high from the cycle after an accepted start until currentfilled is asserted

Behaviour:
- FSM states: IDLE, REQ, DRAIN, DONE. Reset (reset=0, asynchronous) forces IDLE and clears all counters and address registers.
- Output reset values: mem_req=0, mem_addr=0, buf_we=0, buf_addr=0, currentfilled=0, busy=0.
- IDLE:
  - start=1 latches bx=curpos[6:0] and by=curpos[13:7].
  - Base address = by*BLK*FRAME_W + bx*BLK, truncated to ADDR_W bits. It loads both row_addr and mem_addr.
  - Next state is REQ.
  - No range check is made on bx/by.
- REQ:
  - mem_req=1.
  - On each mem_gnt, req_cnt (8 bit) increments and the column steps: mem_addr+1.
  - When req_cnt[3:0]==15, a grant instead sets row_addr += FRAME_W and mem_addr = new row_addr.
  - The grant for req_cnt==255 moves the FSM to DRAIN and drops mem_req the next cycle.
- Responses are accepted in REQ and DRAIN, including overlap with ongoing requests.
  - Response path is combinational: buf_we = mem_rvalid & (state is REQ or DRAIN); buf_addr = resp_cnt; buf_wdata = mem_rdata.
  - resp_cnt (8 bit) increments on each accepted response.
  - The write with resp_cnt==255 moves the FSM to DONE. This is legal from REQ if the memory is zero-latency.
- DONE: currentfilled=1 for exactly one cycle, busy=0, next state IDLE.
- Latency: start at cycle 0, constant grant, read latency L gives grants in cycles 1..256, last write in cycle 256+L, currentfilled in cycle 257+L.
- start while busy or in DONE is ignored, and curpos is not re-sampled.
- mem_rvalid in IDLE or DONE is ignored; no buffer write occurs.
- Reset mid-operation aborts the load with no currentfilled pulse. The memory side is reset by the same reset, so no stale responses follow.

Test Plan:
- curpos={y=0,x=0}, gnt=1, L=2 -> addresses 0..15, then 1280..1295, ...; last address 19215. buf_addr 0..255 written in order. currentfilled in cycle 259, one cycle.
- curpos={y=44,x=79} -> first address 902384, address after 16 grants 903664, last address 921599; currentfilled asserted.
- gnt toggling 1,0,1,0 -> mem_addr held on gnt=0 cycles. Exactly 256 transfers; no address skipped or repeated.
- start re-pulsed with a different curpos at cycle 50 of a load -> ignored. Addresses continue from the original base. Only one currentfilled pulse.
- reset=0 at cycle 100, with 99 grants and about 97 writes done -> all outputs 0 immediately, no currentfilled. A fresh start then loads all 256 pixels correctly.
- L=0 (rvalid in the grant cycle) -> DONE is entered directly from REQ and currentfilled is asserted in cycle 257.
